arb_rr_lock: RTL

//   Round-robin arbiter with registered grant and transaction lock, sharing one

---
 rtl/arb_pkg.sv | 34 +++
 rtl/Arb_n_LSB1.sv | 22 ++
 rtl/arb_rr_lock.sv | 91 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
// Vector helpers work on a fixed 64-bit container; callers size-cast in and out.
package arb_pkg;

  localparam int MAX_REQ = 64;

  typedef logic [MAX_REQ-1:0] vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int unsigned onehot2bin(input vec_t oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  // Bits strictly above w within an n-bit vector; the top requester wraps to all ones.
  function automatic vec_t mask_above(input int unsigned w, input int unsigned n);
    vec_t m;
    m = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (w >= n - 1) m[i] = (unsigned'(i) < n);
      else            m[i] = (unsigned'(i) > w) && (unsigned'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/Arb_n_LSB1.sv
// Fixed-priority picker: one-hot of the lowest set request bit (bit 0 wins).
module Arb_n_LSB1 #(
  parameter int REQ_WIDTH = 16
) (
  input  logic [REQ_WIDTH-1:0] req,
  output logic [REQ_WIDTH-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_lock.sv
// Round-robin arbiter with registered grant held for a whole transaction,
// released on last, req drop, or the hold limit.
module arb_rr_lock
  import arb_pkg::*;
#(
  parameter int REQ_WIDTH = 16,
  parameter int MAX_HOLD  = 64,
  localparam int ID_W     = $clog2(REQ_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_WIDTH-1:0] req,
  input  logic [REQ_WIDTH-1:0] last,
  output logic [REQ_WIDTH-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output state_t               dbg_state,
  output logic [REQ_WIDTH-1:0] dbg_mask
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t                 state_q, state_d;
  logic [REQ_WIDTH-1:0]   mask_q, mask_d;
  logic [REQ_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;

  logic [REQ_WIDTH-1:0]   cand, masked, pick_m, pick_r, winner;
  logic                   owner_req, owner_last, forced, release_now, do_grant;

  // Handshake: a requester holds req high until it sees its grant bit and then
  // through its final beat (flagged by last); grant may move on the cycle after.
  always_comb begin
    owner_req   = |(req & grant_q);
    owner_last  = |(req & last & grant_q);
    forced      = (MAX_HOLD != 0) && (hold_cnt_q == CNT_MAX);
    release_now = (state_q == BUSY) && (!owner_req || owner_last || forced);
    cand        = (state_q == IDLE) ? req : (req & ~grant_q);
    masked      = cand & mask_q;
    winner      = (|masked) ? pick_m : pick_r;
    do_grant    = ((state_q == IDLE) || release_now) && (|cand);
  end

  Arb_n_LSB1 #(.REQ_WIDTH(REQ_WIDTH)) u_pick_masked (.req(masked), .gnt(pick_m));
  Arb_n_LSB1 #(.REQ_WIDTH(REQ_WIDTH)) u_pick_raw    (.req(cand),   .gnt(pick_r));

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    if (do_grant) begin
      state_d    = BUSY;
      grant_d    = winner;
      hold_cnt_d = '0;
      mask_d     = REQ_WIDTH'(mask_above(onehot2bin(vec_t'(winner)), unsigned'(REQ_WIDTH)));
    end else if (release_now) begin
      state_d    = IDLE;
      grant_d    = '0;
      hold_cnt_d = '0;
    end else if (state_q == BUSY && hold_cnt_q != CNT_MAX) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
    grant_id_d = ID_W'(onehot2bin(vec_t'(grant_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= '1;
      grant_q    <= '0;
      grant_id_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign busy      = |grant_q;
  assign dbg_state = state_q;
  assign dbg_mask  = mask_q;

endmodule
